// File: rtl/alu_exec_unit.sv
// Integer execute unit: single-cycle ALU ops plus a 32-step shift-add multiplier.
// Latency: 1 cycle for single-cycle ops, 33 cycles for mul (start edge to done_o).
// Backpressure: start_i is ignored while busy_o is high; nothing is queued.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_JR   = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_LI   = 4'b1000;
    localparam logic [3:0] OP_LUI  = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_SRAV = 4'b1111;

    localparam logic [4:0] LAST_STEP = 5'(MUL_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        alu_res = '0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SRA:  alu_res = $signed(src2_i) >>> shamt_i;
            OP_SRAV: alu_res = $signed(src2_i) >>> src1_i[4:0];
            OP_LUI:  alu_res = {src2_i[15:0], 16'h0000};
            OP_LI:   alu_res = src2_i;
            OP_JR:   alu_res = src1_i;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step; the low product bits are sign-agnostic.
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
            zero_o   <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (start_i) begin
                        if (ctrl_i == OP_MUL) begin
                            state  <= MUL;
                            busy_o <= 1'b1;
                            mcand  <= src1_i;
                            mplier <= src2_i;
                            acc    <= '0;
                            cnt    <= '0;
                        end else begin
                            state    <= DONE;
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            done_o   <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (cnt == LAST_STEP) begin
                        state    <= DONE;
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
